// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor stage resolves X-Y-Bin LSB first,
// one bit per clock, with results published atomically on entry to DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xr, yr;
  logic             br;
  logic [WIDTH-2:0] sreg;

  logic             xb, yb, dbit, bnext, last, accept;
  logic [WIDTH-1:0] dfull;

  // Operand registers shift right, so bit 0 is always the bit being resolved;
  // on the final step it is the captured MSB, which the overflow rule needs.
  always_comb begin
    xb     = xr[0];
    yb     = yr[0];
    dbit   = xb ^ yb ^ br;
    bnext  = (~xb & yb) | (~(xb ^ yb) & br);
    dfull  = {dbit, sreg};
    last   = (cnt == LAST);
    accept = start && (state == IDLE || state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr   <= '0;
      yr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      sreg <= '0;
      D    <= '0;
      Bout <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b1;
    end else if (accept) begin
      xr  <= X;
      yr  <= Y;
      br  <= Bin;
      cnt <= '0;
    end else if (state == RUN) begin
      xr   <= xr >> 1;
      yr   <= yr >> 1;
      br   <= bnext;
      sreg <= dfull[WIDTH-1:1];
      if (last) begin
        D    <= dfull;
        Bout <= bnext;
        V    <= (xb != yb) && (dbit != xb);
        Z    <= (dfull == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
